// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_pkg
// Description : Shared state encoding and gain constants for the noise gate.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_pkg;

    localparam int GAIN_W = 17;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 17'd32768;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } gate_state_t;

endpackage
`default_nettype wire

// File: rtl/abs_sat.sv
`default_nettype none
// ============================================================================
// Module      : abs_sat
// Description : Saturating magnitude of a signed 16-bit sample (-32768 -> 32767).
// Revision    : 1.0 - initial release
// ============================================================================
module abs_sat (
    input  logic signed [15:0] din,
    output logic        [15:0] mag
);

    always_comb begin
        if (din == 16'sh8000) begin
            mag = 16'h7FFF;
        end else if (din[15]) begin
            mag = $unsigned(-din);
        end else begin
            mag = $unsigned(din);
        end
    end

endmodule
`default_nettype wire

// File: rtl/noise_gate.sv
`default_nettype none
// ============================================================================
// Module      : noise_gate
// Description : Level-triggered noise gate with attack/hold/release gain ramps.
// Revision    : 1.0 - initial release
// ============================================================================
module noise_gate
    import gate_pkg::*;
#(
    parameter int HOLD_SAMPLES = 2400,
    parameter int ATTACK_STEP  = 1024,
    parameter int RELEASE_STEP = 64,
    parameter int HYST         = 256
) (
    input  logic               clk_48,
    input  logic               reset_n,
    input  logic               enable,
    input  logic        [15:0] threshold,
    input  logic signed [15:0] gateIn,
    output logic signed [15:0] gateOut,
    output logic               gate_open,
    output logic        [2:0]  gate_state
);

    localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [HOLD_W-1:0] C_HOLD_INIT  = HOLD_W'(HOLD_SAMPLES - 1);
    localparam logic [GAIN_W-1:0] C_ATTACK     = GAIN_W'(ATTACK_STEP);
    localparam logic [GAIN_W-1:0] C_RELEASE    = GAIN_W'(RELEASE_STEP);
    localparam logic [GAIN_W-1:0] C_FIRST_GAIN = (ATTACK_STEP >= 32768) ? GAIN_UNITY : C_ATTACK;
    localparam logic [15:0]       C_HYST       = 16'(HYST);

    gate_state_t               r_state;
    logic        [GAIN_W-1:0]  r_gain;
    logic        [HOLD_W-1:0]  r_hold;
    logic                      r_gate_open;
    logic signed [15:0]        r_x;
    logic signed [15:0]        r_out;

    logic        [15:0]        w_mag;
    logic        [15:0]        w_close_thr;
    logic                      w_trig;
    logic        [GAIN_W:0]    w_attack_sum;
    logic        [GAIN_W-1:0]  w_attack_gain;
    logic        [GAIN_W-1:0]  w_release_gain;
    logic signed [32:0]        w_product;

    abs_sat u_abs_sat (
        .din (gateIn),
        .mag (w_mag)
    );

    assign w_close_thr    = (threshold > C_HYST) ? (threshold - C_HYST) : 16'd0;
    assign w_trig         = (w_mag >= threshold);
    assign w_attack_sum   = {1'b0, r_gain} + {1'b0, C_ATTACK};
    assign w_attack_gain  = (w_attack_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : w_attack_sum[GAIN_W-1:0];
    assign w_release_gain = (r_gain > C_RELEASE) ? (r_gain - C_RELEASE) : '0;

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= CLOSED;
            r_gain      <= '0;
            r_hold      <= '0;
            r_gate_open <= 1'b0;
            r_x         <= '0;
        end else begin
            r_x <= gateIn;
            if (!enable) begin
                r_state     <= OPEN;
                r_gain      <= GAIN_UNITY;
                r_hold      <= '0;
                r_gate_open <= 1'b1;
            end else begin
                case (r_state)
                    CLOSED: begin
                        r_gain <= '0;
                        if (w_trig) begin
                            r_state     <= ATTACK;
                            r_gain      <= C_FIRST_GAIN;
                            r_gate_open <= 1'b1;
                        end
                    end
                    ATTACK: begin
                        r_gain      <= w_attack_gain;
                        r_gate_open <= 1'b1;
                        if (w_attack_gain == GAIN_UNITY) begin
                            r_state <= OPEN;
                        end
                    end
                    OPEN: begin
                        r_gain      <= GAIN_UNITY;
                        r_gate_open <= 1'b1;
                        if (w_mag < w_close_thr) begin
                            r_state <= HOLD;
                            r_hold  <= C_HOLD_INIT;
                        end
                    end
                    HOLD: begin
                        r_gain      <= GAIN_UNITY;
                        r_gate_open <= 1'b1;
                        if (w_trig) begin
                            r_state <= OPEN;
                        end else if (r_hold == '0) begin
                            r_state <= RELEASE;
                            r_gain  <= w_release_gain;
                        end else begin
                            r_hold <= r_hold - 1'b1;
                        end
                    end
                    RELEASE: begin
                        r_gate_open <= 1'b1;
                        // Re-trigger resumes the attack ramp from wherever release had reached.
                        if (w_trig) begin
                            r_state <= ATTACK;
                            r_gain  <= w_attack_gain;
                        end else begin
                            r_gain <= w_release_gain;
                            if (w_release_gain == '0) begin
                                r_state     <= CLOSED;
                                r_gate_open <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state     <= CLOSED;
                        r_gain      <= '0;
                        r_gate_open <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Product fits in 33 bits; at unity gain the shift returns r_x bit-exact.
    assign w_product = $signed({{17{r_x[15]}}, r_x}) * $signed({16'd0, r_gain});

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
        end else begin
            r_out <= 16'(w_product >>> 15);
        end
    end

    assign gateOut    = r_out;
    assign gate_open  = r_gate_open;
    assign gate_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_noise_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_noise_gate
// Description : Self-checking bench: vector table, corner sequences, random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noise_gate;

    localparam int HOLD_SAMPLES = 2400;
    localparam int ATTACK_STEP  = 1024;
    localparam int RELEASE_STEP = 64;
    localparam int HYST         = 256;
    localparam int UNITY        = 32768;

    localparam int S_CLOSED  = 0;
    localparam int S_ATTACK  = 1;
    localparam int S_OPEN    = 2;
    localparam int S_HOLD    = 3;
    localparam int S_RELEASE = 4;

    logic               clk_48 = 1'b0;
    logic               reset_n;
    logic               enable;
    logic        [15:0] threshold;
    logic signed [15:0] gateIn;
    logic signed [15:0] gateOut;
    logic               gate_open;
    logic        [2:0]  gate_state;

    noise_gate #(
        .HOLD_SAMPLES (HOLD_SAMPLES),
        .ATTACK_STEP  (ATTACK_STEP),
        .RELEASE_STEP (RELEASE_STEP),
        .HYST         (HYST)
    ) dut (
        .clk_48     (clk_48),
        .reset_n    (reset_n),
        .enable     (enable),
        .threshold  (threshold),
        .gateIn     (gateIn),
        .gateOut    (gateOut),
        .gate_open  (gate_open),
        .gate_state (gate_state)
    );

    always #5 clk_48 = ~clk_48;

    int total = 0;
    int bad   = 0;

    // Reference model: gain as a plain integer, output from the previous sample.
    int m_state, m_gain, m_hold, m_x, m_out;

    typedef struct {
        int x;
        int thr;
        bit en;
        int exp_out;
        int exp_state;
        bit exp_open;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int clamp16(input int v);
        return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
    endfunction

    task automatic model_reset();
        m_state = S_CLOSED;
        m_gain  = 0;
        m_hold  = 0;
        m_x     = 0;
        m_out   = 0;
    endtask

    task automatic model_edge(input int x, input int thr, input bit en);
        int  level;
        int  close_level;
        bit  loud;
        longint prod;
        prod  = longint'(m_x) * longint'(m_gain);
        m_out = int'(prod >>> 15);
        level = (x < 0) ? -x : x;
        if (level > 32767) level = 32767;
        close_level = max_i(thr - HYST, 0);
        loud = (level >= thr);
        if (!en) begin
            m_state = S_OPEN;
            m_gain  = UNITY;
            m_hold  = 0;
        end else if (m_state == S_CLOSED) begin
            if (loud) begin
                m_state = S_ATTACK;
                m_gain  = min_i(ATTACK_STEP, UNITY);
            end else begin
                m_gain = 0;
            end
        end else if (m_state == S_ATTACK) begin
            m_gain = min_i(m_gain + ATTACK_STEP, UNITY);
            if (m_gain == UNITY) m_state = S_OPEN;
        end else if (m_state == S_OPEN) begin
            if (level < close_level) begin
                m_state = S_HOLD;
                m_hold  = HOLD_SAMPLES - 1;
            end
        end else if (m_state == S_HOLD) begin
            if (loud) begin
                m_state = S_OPEN;
            end else if (m_hold == 0) begin
                m_state = S_RELEASE;
                m_gain  = max_i(m_gain - RELEASE_STEP, 0);
            end else begin
                m_hold = m_hold - 1;
            end
        end else begin
            if (loud) begin
                m_state = S_ATTACK;
                m_gain  = min_i(m_gain + ATTACK_STEP, UNITY);
            end else begin
                m_gain = max_i(m_gain - RELEASE_STEP, 0);
                if (m_gain == 0) m_state = S_CLOSED;
            end
        end
        m_x = x;
    endtask

    task automatic tick(input int x, input int thr, input bit en);
        gateIn    = 16'(x);
        threshold = 16'(thr);
        enable    = en;
        @(posedge clk_48);
        model_edge(x, thr, en);
        #1;
        check("out", int'(gateOut), m_out);
        check("state", int'(gate_state), m_state);
        check("open", int'(gate_open), (m_state != S_CLOSED) ? 1 : 0);
    endtask

    task automatic do_reset();
        @(negedge clk_48);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_48);
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        vecs[0]  = '{100,    1000, 1'b1,      0, 0, 1'b0};
        vecs[1]  = '{-32768, 1000, 1'b1,      0, 1, 1'b1};
        vecs[2]  = '{-32768, 1000, 1'b1,  -1024, 1, 1'b1};
        vecs[3]  = '{32767,  1000, 1'b1,  -2048, 1, 1'b1};
        vecs[4]  = '{0,      1000, 1'b1,   3071, 1, 1'b1};
        vecs[5]  = '{-1,     1000, 1'b1,      0, 1, 1'b1};
        vecs[6]  = '{0,      1000, 1'b1,     -1, 1, 1'b1};
        vecs[7]  = '{1234,   1000, 1'b0,      0, 2, 1'b1};
        vecs[8]  = '{-32768, 1000, 1'b0,   1234, 2, 1'b1};
        vecs[9]  = '{-5,     1000, 1'b1, -32768, 3, 1'b1};
        vecs[10] = '{800,    1000, 1'b1,     -5, 3, 1'b1};
        vecs[11] = '{1000,   1000, 1'b1,    800, 2, 1'b1};
        vecs[12] = '{744,    1000, 1'b1,   1000, 2, 1'b1};
        vecs[13] = '{743,    1000, 1'b1,    744, 3, 1'b1};

        reset_n   = 1'b0;
        enable    = 1'b1;
        threshold = 16'd1000;
        gateIn    = '0;
        model_reset();
        repeat (3) @(posedge clk_48);
        #1;
        check("reset_out", int'(gateOut), 0);
        check("reset_state", int'(gate_state), S_CLOSED);
        check("reset_open", int'(gate_open), 0);
        @(negedge clk_48);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            gateIn    = 16'(vecs[i].x);
            threshold = 16'(vecs[i].thr);
            enable    = vecs[i].en;
            @(posedge clk_48);
            #1;
            check($sformatf("vec%0d_out", i), int'(gateOut), vecs[i].exp_out);
            check($sformatf("vec%0d_state", i), int'(gate_state), vecs[i].exp_state);
            check($sformatf("vec%0d_open", i), int'(gate_open), int'(vecs[i].exp_open));
        end

        // Quiet input below threshold keeps the gate shut.
        do_reset();
        repeat (5000) tick(100, 1000, 1'b1);
        check("quiet_open", int'(gate_open), 0);

        for (int i = 0; i < 32; i++) begin
            tick(10000, 1000, 1'b1);
            if (i == 16) check("attack_half", int'(gateOut), 5000);
        end
        check("attack_done", int'(gate_state), S_OPEN);
        tick(10000, 1000, 1'b1);
        check("open_unity", int'(gateOut), 10000);

        tick(500, 1000, 1'b1);
        n = 0;
        while (gate_state == 3'(S_HOLD) && n < 3000) begin
            tick(500, 1000, 1'b1);
            n++;
        end
        check("hold_len", n, 2400);
        n = 1;
        while (gate_state == 3'(S_RELEASE) && n < 1000) begin
            tick(500, 1000, 1'b1);
            n++;
        end
        check("release_len", n, 512);
        tick(500, 1000, 1'b1);
        check("closed_out", int'(gateOut), 0);

        // Re-trigger halfway through release.
        repeat (32) tick(10000, 1000, 1'b1);
        repeat (2401) tick(500, 1000, 1'b1);
        repeat (255) tick(500, 1000, 1'b1);
        tick(10000, 1000, 1'b1);
        n = 1;
        while (gate_state == 3'(S_ATTACK) && n < 100) begin
            tick(10000, 1000, 1'b1);
            n++;
        end
        check("retrigger_len", n, 16);

        tick(500, 1000, 1'b1);
        repeat (100) tick(800, 1000, 1'b1);
        check("hyst_hold", int'(gate_state), S_HOLD);
        repeat (3000) tick(0, 1000, 1'b1);
        check("closed_again", int'(gate_state), S_CLOSED);

        for (int i = 0; i < 20; i++) begin
            tick(int'($urandom_range(0, 65535)) - 32768, 1000, 1'b0);
        end
        check("bypass_open", int'(gate_open), 1);
        repeat (5) tick(0, 1000, 1'b1);

        // Asynchronous reset in the middle of an attack ramp.
        do_reset();
        repeat (5) tick(10000, 1000, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_out", int'(gateOut), 0);
        check("async_state", int'(gate_state), S_CLOSED);
        check("async_open", int'(gate_open), 0);
        model_reset();
        @(negedge clk_48);
        reset_n = 1'b1;
        repeat (3) tick(0, 1000, 1'b1);

        for (int p = 0; p < 40; p++) begin
            int thr;
            int len;
            int regime;
            bit en;
            case ($urandom_range(0, 7))
                0: thr = 0;
                1: thr = 255;
                2: thr = 256;
                3: thr = 257;
                4: thr = 1000;
                5: thr = 20000;
                default: thr = int'($urandom_range(0, 65535));
            endcase
            regime = int'($urandom_range(0, 3));
            len    = (regime == 1) ? int'($urandom_range(100, 3000)) : int'($urandom_range(20, 400));
            en     = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < len; i++) begin
                int x;
                case (regime)
                    0: x = int'($urandom_range(0, 65535)) - 32768;
                    1: x = int'($urandom_range(0, 600)) - 300;
                    2: x = thr - 300 + int'($urandom_range(0, 600));
                    default: x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                                             : int'($urandom_range(0, 100)) - 50;
                endcase
                if (regime == 2 && $urandom_range(0, 1) == 1) x = -x;
                tick(clamp16(x), thr, en);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noise_gate.md
Name: noise_gate

Overview:
- Sample-rate downstream stage of the channel strip. It consumes the 16-bit filtered sample stream on clk_48 and mutes the signal when its level stays below a threshold.
- Gain is a smoothed Q1.15 multiplier under a 5-state FSM: attack ramp, hold timer and release ramp. This avoids clicks at gate transitions.
- Single clock domain; one sample per clk_48 posedge.

Parameters:
- HOLD_SAMPLES, 2400, samples the gate stays open after level drops (50 ms at 48 kHz).
- ATTACK_STEP, 1024, gain increment per sample in ATTACK (32 samples from 0 to unity).
- RELEASE_STEP, 64, gain decrement per sample in RELEASE (512 samples from unity to 0).
- HYST, 256, close threshold is threshold-HYST, saturated at 0.

Ports:
- clk_48  in  1  sample clock; all registers update on posedge.
- reset_n  in  1  reset.
- enable  in  1  0 = bypass (unity gain), 1 = gating active.
- threshold  in  16  unsigned open level, compared against |gateIn|.
- gateIn  in  16  signed input sample.
- gateOut  out  16  signed gated output sample, registered.
- gate_open  out  1  registered; 1 when state != CLOSED.
- gate_state  out  3  registered FSM state encoding, for UI/LEDs.

Interface (already decided): reset reset_n, asynchronous, active-low; clock clk_48.

Behaviour:
- Reset values: gateOut=0, gate_open=0, gate_state=CLOSED, gain=0, x_r=0, hold_cnt=0. Assertion mid-operation forces these values immediately (asynchronous).
- Magnitude: mag = |gateIn|, with -32768 mapped to 32767. Computed combinationally from the current gateIn.
- Edge k:
  - x_r <= gateIn.
  - The FSM evaluates mag and updates state and gain.
- Edge k+1: gateOut <= (x_r * gain) >>> 15.
- Latency is exactly 1 cycle. The sample captured at edge k is scaled by the gain decided at edge k.
- Arithmetic:
  - gain is unsigned 17-bit, range 0..32768 (32768 = unity).
  - Product is 33-bit signed.
  - At unity, gateOut == x_r bit-exact, including -32768. No clipping is needed.
- FSM transitions:
  - CLOSED: gain=0. If mag >= threshold -> ATTACK; gain <= min(ATTACK_STEP, 32768).
  - ATTACK: gain <= min(gain+ATTACK_STEP, 32768). On reaching 32768 -> OPEN. Level is ignored during attack.
  - OPEN: gain=32768. If mag < close_thr -> HOLD, hold_cnt <= HOLD_SAMPLES-1. Otherwise stay.
  - HOLD: gain=32768.
    - If mag >= threshold -> OPEN.
    - Else if hold_cnt==0 -> RELEASE; gain <= max(gain-RELEASE_STEP, 0).
    - Else hold_cnt--.
  - RELEASE:
    - If mag >= threshold -> ATTACK, ramping from the current gain; that edge applies gain+ATTACK_STEP.
    - Else gain <= max(gain-RELEASE_STEP, 0); on reaching 0 -> CLOSED.
- Hysteresis: close_thr = (threshold > HYST) ? threshold-HYST : 0. Levels in [close_thr, threshold) keep OPEN open but do not re-trigger from HOLD.
- threshold = 0: the gate opens on any sample and never closes.
- threshold changes take effect on the next edge, with no state reset.
- enable=0:
  - FSM forced to OPEN, gain=32768, hold_cnt=0, so gateOut = previous gateIn.
  - On re-enable, operation continues from OPEN.
- Unused state encodings recover to CLOSED with gain=0.

Decomposition:
- Package gate_pkg holds:
  - enum gate_state_t {CLOSED, ATTACK, OPEN, HOLD, RELEASE} on 3 bits;
  - GAIN_UNITY=32768;
  - GAIN_W=17.
- Sub-module abs_sat: signed 16 -> unsigned 16 saturating magnitude, combinational.
- FSM, ramps and multiplier stay in noise_gate.

Test Plan:
- Reset, then gateIn=100 constant, threshold=1000, enable=1 -> gateOut=0 and gate_open=0 for 5000 cycles.
- Step gateIn to 10000 -> ATTACK on that edge; gain 1024,2048,...,32768 over 32 edges, then OPEN. gateOut=5000 when gain=16384; thereafter gateOut=10000.
- From OPEN, gateIn=500 (< 744) -> HOLD; gateOut=500 for 2400 cycles. Then RELEASE over 512 cycles (gateOut=250 at gain 16384), then CLOSED with gateOut=0.
- Re-trigger in RELEASE at gain=16384 with gateIn=10000 -> ATTACK; unity reached after 16 edges. Also: gateIn=800 during HOLD (between 744 and 1000) -> stays HOLD and does not reopen.
- Open gate with gateIn=-32768 -> mag=32767 opens. At unity gateOut=-32768 exactly; gateIn=32767 -> 32767.
- enable=0 while CLOSED -> gateOut equals gateIn delayed 1 cycle, gate_open=1. Separately, reset_n low mid-ATTACK -> gateOut=0, gate_state=CLOSED immediately, without waiting for a clock edge.
